// File: rtl/demux_scan_pkg.sv
// Shared definitions for the demux scan controller.
//   state_t      : scan FSM state encoding (IDLE, SCAN, DONE)
//   NCH_DEF      : default number of demux output channels
//   DWELL_W_DEF  : default width of the per-channel dwell count
//   SEL_W        : width of the channel select
package demux_scan_pkg;

  localparam int NCH_DEF     = 8;
  localparam int DWELL_W_DEF = 4;
  localparam int SEL_W       = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/demux_1to8.sv
// 1-to-8 demultiplexer: routes din to y[sel]; every other output is 0.
//   din : input  data bit
//   sel : input  channel select (3 bits)
//   y   : output one-hot-routed data (8 bits)
module demux_1to8 (
  input  logic       din,
  input  logic [2:0] sel,
  output logic [7:0] y
);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    y      = 8'h00;
    y[sel] = din;
  end

endmodule

// File: rtl/demux_scan_controller.sv
// Scan controller: walks the enabled channels of an 8-way demux in ascending
// order, holding each for dwell+1 cycles, then pulses done for one cycle.
//   clk     : input  clock, all state updates on the rising edge
//   rst     : input  synchronous active-high reset
//   start   : input  begin one scan (only looked at in IDLE)
//   en_mask : input  channels to visit, latched at start
//   dwell   : input  extra hold cycles per channel, latched at start
//   Din     : input  serial data routed to the selected channel
//   S       : output current channel select (0 when not busy)
//   Y       : output demux outputs (all 0 when not busy)
//   busy    : output high while a scan is in progress
//   done    : output one-cycle pulse when the scan completes
module demux_scan_controller
  import demux_scan_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NCH-1:0]     en_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               Din,
  output logic [SEL_W-1:0]   S,
  output logic [NCH-1:0]     Y,
  output logic               busy,
  output logic               done
);

  state_t             state_q, state_d;
  logic [NCH-1:0]     mask_q,  mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q,   cnt_d;
  logic [SEL_W-1:0]   sel_q,   sel_d;
  logic [SEL_W:0]     nxt;

  // Index of the lowest set bit; only called with a non-zero mask.
  function automatic logic [SEL_W-1:0] first_set(input logic [NCH-1:0] mask);
    logic [SEL_W-1:0] idx;
    idx = '0;
    // Descending walk so the lowest set bit is the last one written.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  // {found, index} of the lowest set bit strictly above cur. Channel 7 has
  // nothing above it, so the scan never wraps back to lower channels.
  function automatic logic [SEL_W:0] next_set(input logic [NCH-1:0] mask,
                                              input logic [SEL_W-1:0] cur);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) r = {1'b1, SEL_W'(i)};
    end
    return r;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    nxt     = next_set(mask_q, sel_q);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (en_mask != '0) begin
            mask_d  = en_mask;
            dwell_d = dwell;
            sel_d   = first_set(en_mask);
            cnt_d   = '0;
            state_d = SCAN;
          end else begin
            // Nothing to scan: report completion straight away.
            state_d = DONE;
          end
        end
      end
      SCAN: begin
        if (cnt_q == dwell_q) begin
          if (nxt[SEL_W]) begin
            sel_d = nxt[SEL_W-1:0];
            cnt_d = '0;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        sel_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SCAN);
  assign done = (state_q == DONE);
  assign S    = busy ? sel_q : '0;

  // Gating Din with busy keeps Y at zero outside a scan.
  demux_1to8 u_demux (
    .din (Din & busy),
    .sel (S),
    .y   (Y)
  );

endmodule
